// File: rtl/image_block_packer_if.sv
// Pixel-in / block-out bundle for image_block_packer.
// master: the packer side (consumes pixels, produces blocks).
// slave : the environment side (produces pixels, consumes blocks).
interface image_block_packer_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int PIXEL_WIDTH = 8,
  parameter int INDEX_WIDTH = 16
);
  logic                   s_pixel_valid;
  logic                   s_pixel_ready;
  logic [PIXEL_WIDTH-1:0] s_pixel_data;
  logic                   s_pixel_last;
  logic                   m_block_valid;
  logic                   m_block_ready;
  logic [DATA_WIDTH-1:0]  m_block_data;
  logic [INDEX_WIDTH-1:0] m_block_index;
  logic                   m_block_last;
  logic [5:0]             m_pad_count;

  modport master (
    input  s_pixel_valid, s_pixel_data, s_pixel_last, m_block_ready,
    output s_pixel_ready, m_block_valid, m_block_data, m_block_index,
           m_block_last, m_pad_count
  );

  modport slave (
    output s_pixel_valid, s_pixel_data, s_pixel_last, m_block_ready,
    input  s_pixel_ready, m_block_valid, m_block_data, m_block_index,
           m_block_last, m_pad_count
  );
endinterface

// File: rtl/image_block_packer.sv
// image_block_packer: packs a pixel stream into DATA_WIDTH plaintext blocks,
// first pixel in the most significant byte, short final blocks padded.
// Optional feature macro PACKER_PKCS_PAD_EN: pad bytes carry the pad count,
// and an image ending exactly on a block boundary gets one extra full pad block.
module image_block_packer #(
  parameter int DATA_WIDTH  = 256,
  parameter int PIXEL_WIDTH = 8,
  parameter int INDEX_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 key_ready,
  image_block_packer_if.master io_bus
);
  localparam int N     = DATA_WIDTH / PIXEL_WIDTH;
  localparam int CNT_W = $clog2(N + 1);
`ifdef PACKER_PKCS_PAD_EN
  localparam bit PKCS_EN = 1'b1;
`else
  localparam bit PKCS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FILL, HOLD, DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CNT_W-1:0]       r_fill_count;
  logic [INDEX_WIDTH-1:0] r_index;
  logic                   r_last;
  logic [5:0]             r_pad_count;
  logic                   r_extra_pending;
  logic [PIXEL_WIDTH-1:0] r_slot [N];

  logic                   w_pixel_ready;
  logic                   w_block_valid;
  logic                   w_pixel_fire;
  logic                   w_block_fire;
  logic                   w_block_full;
  logic                   w_block_end;
  logic [CNT_W-1:0]       w_remaining;
  logic [PIXEL_WIDTH-1:0] w_pad_byte;
  logic [DATA_WIDTH-1:0]  w_data;

  assign w_pixel_fire = io_bus.s_pixel_valid && w_pixel_ready;
  assign w_block_fire = w_block_valid && io_bus.m_block_ready;
  assign w_block_full = (r_fill_count == CNT_W'(N - 1));
  assign w_block_end  = w_pixel_fire && (w_block_full || io_bus.s_pixel_last);
  // Bytes still empty after the pixel being accepted now.
  assign w_remaining  = CNT_W'(N - 1) - r_fill_count;
  assign w_pad_byte   = PKCS_EN ? PIXEL_WIDTH'(w_remaining) : '0;

  // State register; reset aborts any block in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic; key_ready only matters while idle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (key_ready) w_state_next = FILL;
      FILL: if (w_block_end) w_state_next = HOLD;
      HOLD: if (w_block_fire) begin
        if (r_extra_pending) w_state_next = HOLD;
        else if (r_last)     w_state_next = DONE;
        else                 w_state_next = FILL;
      end
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    w_pixel_ready = 1'b0;
    w_block_valid = 1'b0;
    case (r_state)
      FILL: w_pixel_ready = 1'b1;
      HOLD: w_block_valid = 1'b1;
      default: ;
    endcase
  end

  // Block bookkeeping: fill count, index, last flag, pad count, extra pad block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fill_count    <= '0;
      r_index         <= '0;
      r_last          <= 1'b0;
      r_pad_count     <= '0;
      r_extra_pending <= 1'b0;
    end else begin
      if (w_pixel_fire) begin
        if (w_block_end) begin
          r_fill_count    <= '0;
          // A full final block under PKCS padding is followed by a pad-only block.
          r_last          <= io_bus.s_pixel_last && !(PKCS_EN && w_block_full);
          r_extra_pending <= PKCS_EN && io_bus.s_pixel_last && w_block_full;
          r_pad_count     <= 6'(w_remaining);
        end else begin
          r_fill_count <= r_fill_count + 1'b1;
        end
      end
      if (w_block_fire) begin
        r_index <= r_index + 1'b1;
        if (r_extra_pending) begin
          r_extra_pending <= 1'b0;
          r_last          <= 1'b1;
          r_pad_count     <= 6'(N);
        end
      end
      if (r_state == DONE) r_index <= '0;
    end
  end

  // Byte slots: slot 0 is the MSB byte; the final pixel also pads every later slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) r_slot[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_pixel_fire) begin
          if (CNT_W'(i) == r_fill_count)
            r_slot[i] <= io_bus.s_pixel_data;
          else if (io_bus.s_pixel_last && (CNT_W'(i) > r_fill_count))
            r_slot[i] <= w_pad_byte;
        end else if (w_block_fire && r_extra_pending) begin
          r_slot[i] <= PIXEL_WIDTH'(N);
        end
      end
    end
  end

  // Flatten slots into the output word, slot 0 at the top.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++)
      w_data[DATA_WIDTH-1-i*PIXEL_WIDTH -: PIXEL_WIDTH] = r_slot[i];
  end

  assign io_bus.s_pixel_ready = w_pixel_ready;
  assign io_bus.m_block_valid = w_block_valid;
  assign io_bus.m_block_data  = w_data;
  assign io_bus.m_block_index = r_index;
  assign io_bus.m_block_last  = r_last;
  assign io_bus.m_pad_count   = r_pad_count;
endmodule

// File: tb/tb_image_block_packer.sv
// Directed bench for image_block_packer (default parameters).
module tb_image_block_packer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic key_ready = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [255:0] exp_data;

  image_block_packer_if bus ();

  image_block_packer dut (
    .clk(clk),
    .reset_n(reset_n),
    .key_ready(key_ready),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    bus.s_pixel_valid = 1'b1;
    bus.s_pixel_data  = d;
    bus.s_pixel_last  = l;
    while (!bus.s_pixel_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("ready_timeout", 256'(t), 256'd0);
    @(negedge clk);
    bus.s_pixel_valid = 1'b0;
    bus.s_pixel_last  = 1'b0;
  endtask

  task automatic show_block();
    $display("block idx=%0d last=%0d pad=%0d data=%h", bus.m_block_index,
             bus.m_block_last, bus.m_pad_count, bus.m_block_data);
  endtask

  initial begin
    bus.s_pixel_valid = 1'b0;
    bus.s_pixel_data  = 8'h00;
    bus.s_pixel_last  = 1'b0;
    bus.m_block_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", 256'(bus.s_pixel_ready), 256'd0);
    check("rst_valid", 256'(bus.m_block_valid), 256'd0);
    check("rst_last",  256'(bus.m_block_last),  256'd0);
    check("rst_data",  bus.m_block_data,        256'd0);
    check("rst_index", 256'(bus.m_block_index), 256'd0);
    check("rst_pad",   256'(bus.m_pad_count),   256'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // No key: pixels offered, nothing accepted; stray m_block_ready ignored
    bus.s_pixel_valid = 1'b1;
    bus.s_pixel_data  = 8'h77;
    bus.m_block_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("nokey_ready", 256'(bus.s_pixel_ready), 256'd0);
    end
    check("nokey_valid", 256'(bus.m_block_valid), 256'd0);
    check("nokey_index", 256'(bus.m_block_index), 256'd0);
    bus.s_pixel_valid = 1'b0;
    key_ready = 1'b1;

    // 0x00..0x1F, last on 32nd byte: full final block, no padding
    for (int i = 0; i < 32; i++) send_byte(8'(i), i == 31);
    show_block();
    check("b0_valid", 256'(bus.m_block_valid), 256'd1);
    check("b0_data", bus.m_block_data,
          256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    check("b0_index", 256'(bus.m_block_index), 256'd0);
`ifdef PACKER_PKCS_PAD_EN
    check("b0_last", 256'(bus.m_block_last), 256'd0);
    check("b0_pad",  256'(bus.m_pad_count),  256'd0);
    @(negedge clk);
    show_block();
    check("b0x_data", bus.m_block_data, {32{8'h20}});
    check("b0x_last", 256'(bus.m_block_last), 256'd1);
    check("b0x_pad",  256'(bus.m_pad_count),  256'd32);
`else
    check("b0_last", 256'(bus.m_block_last), 256'd1);
    check("b0_pad",  256'(bus.m_pad_count),  256'd0);
`endif
    @(negedge clk);
    check("done_valid", 256'(bus.m_block_valid), 256'd0);
    @(negedge clk);
    check("idle_index", 256'(bus.m_block_index), 256'd0);

    // Two back-to-back blocks, first stalled downstream for 5 cycles
    bus.m_block_ready = 1'b0;
    exp_data = '0;
    for (int i = 0; i < 32; i++) begin
      exp_data = {exp_data[247:0], 8'(8'h40 + i)};
      send_byte(8'(8'h40 + i), 1'b0);
    end
    show_block();
    bus.s_pixel_valid = 1'b1;
    bus.s_pixel_data  = 8'hEE;
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 256'(bus.m_block_valid), 256'd1);
      check("stall_data",  bus.m_block_data, exp_data);
      check("stall_index", 256'(bus.m_block_index), 256'd0);
      check("stall_ready", 256'(bus.s_pixel_ready), 256'd0);
      @(negedge clk);
    end
    bus.s_pixel_valid = 1'b0;
    bus.m_block_ready = 1'b1;
    @(negedge clk);
    check("hs_valid", 256'(bus.m_block_valid), 256'd0);
    check("hs_index", 256'(bus.m_block_index), 256'd1);
    exp_data = '0;
    for (int i = 0; i < 32; i++) begin
      exp_data = {exp_data[247:0], 8'(8'h80 + i)};
      send_byte(8'(8'h80 + i), 1'b0);
    end
    show_block();
    check("b1_data",  bus.m_block_data, exp_data);
    check("b1_index", 256'(bus.m_block_index), 256'd1);
    check("b1_last",  256'(bus.m_block_last), 256'd0);
    @(negedge clk);

    // Short final block: 5 x 0xAA
    for (int i = 0; i < 5; i++) send_byte(8'hAA, i == 4);
    show_block();
`ifdef PACKER_PKCS_PAD_EN
    exp_data = {40'hAAAAAAAAAA, {27{8'h1b}}};
`else
    exp_data = {40'hAAAAAAAAAA, 216'd0};
`endif
    check("short_data",  bus.m_block_data, exp_data);
    check("short_pad",   256'(bus.m_pad_count), 256'd27);
    check("short_last",  256'(bus.m_block_last), 256'd1);
    check("short_index", 256'(bus.m_block_index), 256'd2);
    @(negedge clk);
    @(negedge clk);
    check("short_clr_index", 256'(bus.m_block_index), 256'd0);

    // Reset mid-block discards the partial block
    for (int i = 0; i < 12; i++) send_byte(8'h55, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", 256'(bus.s_pixel_ready), 256'd0);
    check("mid_rst_valid", 256'(bus.m_block_valid), 256'd0);
    check("mid_rst_data",  bus.m_block_data, 256'd0);
    check("mid_rst_pad",   256'(bus.m_pad_count), 256'd0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_data = '0;
    for (int i = 0; i < 32; i++) begin
      exp_data = {exp_data[247:0], 8'(8'hC0 + i)};
      send_byte(8'(8'hC0 + i), 1'b0);
    end
    show_block();
    check("fresh_valid", 256'(bus.m_block_valid), 256'd1);
    check("fresh_data",  bus.m_block_data, exp_data);
    check("fresh_index", 256'(bus.m_block_index), 256'd0);
    check("fresh_pad",   256'(bus.m_pad_count), 256'd0);
    @(negedge clk);
    check("fresh_hs_valid", 256'(bus.m_block_valid), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/image_block_packer.md
IMAGE_BLOCK_PACKER -- requirements
Module: image_block_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256: width of one cipher block in bits.
REQ-002 SHALL have parameter PIXEL_WIDTH, default 8: width of one input pixel in bits.
REQ-003 SHALL have parameter INDEX_WIDTH, default 16: width of the block index counter.
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port key_ready  input  1  level; high once the key schedule is complete.
REQ-007 SHALL have port s_pixel_valid  input  1  input pixel valid.
REQ-008 SHALL have port s_pixel_ready  output  1  packer accepts a pixel this cycle.
REQ-009 SHALL have port s_pixel_data  input  PIXEL_WIDTH  pixel value.
REQ-010 SHALL have port s_pixel_last  input  1  marks the final pixel of the image.
REQ-011 SHALL have port m_block_valid  output  1  packed block available.
REQ-012 SHALL have port m_block_ready  input  1  downstream encryptor accepts the block.
REQ-013 SHALL have port m_block_data  output  DATA_WIDTH  packed plaintext block.
REQ-014 SHALL have port m_block_index  output  INDEX_WIDTH  zero-based block number within the image.
REQ-015 SHALL have port m_block_last  output  1  block is the final block of the image.
REQ-016 SHALL have port m_pad_count  output  6  number of padded bytes in the block, 0..32.

Function
REQ-017 SHALL implement states IDLE, FILL, HOLD, DONE; N = DATA_WIDTH/PIXEL_WIDTH = 32 bytes per block.
REQ-018 IDLE SHALL move to FILL when key_ready=1; key_ready SHALL be ignored in every other state.
REQ-019 s_pixel_ready SHALL equal 1 only in FILL; a pixel transfers on s_pixel_valid && s_pixel_ready.
REQ-020 The first pixel of a block SHALL occupy m_block_data[255:248], the k-th pixel bits [255-8k:248-8k].
REQ-021 FILL SHALL move to HOLD on the cycle the 32nd byte or an s_pixel_last byte transfers; m_block_valid SHALL be 1 on the next cycle.
REQ-022 On s_pixel_last with fewer than 32 bytes filled, the remaining low bytes SHALL be padded per REQ-033/034 and m_pad_count SHALL equal 32 minus bytes filled.
REQ-023 In HOLD, m_block_data, m_block_index, m_block_last, m_pad_count SHALL be stable until m_block_valid && m_block_ready.
REQ-024 On the HOLD handshake, m_block_index SHALL increment modulo 2^INDEX_WIDTH, and the FSM SHALL return to FILL, or go to DONE if m_block_last was 1.
REQ-025 DONE SHALL move to IDLE on the next cycle, and the index SHALL clear to 0.
REQ-026 m_block_ready asserted while m_block_valid=0 SHALL have no effect.
REQ-027 s_pixel_last on the 32nd byte SHALL produce m_block_last=1 with m_pad_count=0, unless REQ-034 applies.
REQ-028 Block throughput SHALL be at most one block per 33 cycles (32 fill cycles plus 1 HOLD handshake cycle).

Reset
REQ-029 On reset_n=0, the FSM SHALL go to IDLE immediately, including mid-block.
REQ-030 On reset_n=0, s_pixel_ready, m_block_valid, m_block_last SHALL be 0.
REQ-031 On reset_n=0, m_block_data, m_block_index, m_pad_count and the fill counter SHALL be 0.
REQ-032 A partially filled block SHALL be discarded on reset; no output SHALL result from it.

Configuration
REQ-033 Without PACKER_PKCS_PAD_EN: pad bytes SHALL be 8'h00, and no extra block SHALL be emitted when the image ends on a block boundary.
REQ-034 With PACKER_PKCS_PAD_EN: each pad byte SHALL equal m_pad_count, and if s_pixel_last lands on the 32nd byte, that block SHALL have m_block_last=0 and one extra block of 32 bytes of 8'h20 SHALL follow, with m_block_last=1 and m_pad_count=32.

Verification
REQ-035 key_ready=0, s_pixel_valid=1 held for 10 cycles -> s_pixel_ready stays 0 and no block is emitted.
REQ-036 key_ready=1, bytes 0x00..0x1F streamed back-to-back, m_block_ready=1 -> m_block_data=0x000102..1F, index 0, valid asserted 1 cycle after the last byte.
REQ-037 64 bytes streamed, m_block_ready=0 for 5 cycles on block 0 -> outputs held stable, s_pixel_ready=0, block 1 emitted with index 1.
REQ-038 5 bytes 0xAA with last on the 5th, macro off -> data 0xAAAAAAAAAA followed by 27 bytes of 00, m_pad_count=27, m_block_last=1.
REQ-039 Same stimulus as REQ-038 with macro on -> pad bytes 0x1B; with 32 bytes and last on the 32nd -> two blocks, the second all 0x20 with m_pad_count=32.
REQ-040 reset_n pulsed low after 12 bytes, then 32 fresh bytes streamed -> one block containing only the fresh bytes, index 0.
